regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write/two-read integer register file. It adds:
- configurable data width, depth and read-port count
- two write ports with defined collision priority
- optional write-to-read bypass
- a per-register pending-write scoreboard (busy bits plus pending count) used by the pipeline hazard unit

It sits between decode (reads, allocation) and writeback (two retire lanes).

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >=2)
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy, writes ignored
AW (localparam), $clog2(DEPTH), address width
CW (localparam), $clog2(DEPTH+1), pending-count width

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_rs_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
o_rs_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
o_rs_busy  out  NUM_RD  1 = register read on port k has an outstanding producer
i_wr0_en  in  1  write port 0 enable
i_wr0_addr  in  AW  write port 0 address
i_wr0_data  in  DATA_W  write port 0 data
i_wr1_en  in  1  write port 1 enable
i_wr1_addr  in  AW  write port 1 address
i_wr1_data  in  DATA_W  write port 1 data
i_alloc_en  in  1  mark destination as pending (issued producer)
i_alloc_addr  in  AW  register being allocated
o_pending  out  CW  number of registers currently busy

Behaviour:
- Reset (i_rst low, asynchronous): all registers = 0, all busy bits = 0, o_pending = 0 immediately. Outputs are combinational from state, so o_rs_data = 0 and o_rs_busy = 0 while in reset. Reset release takes effect at the next edge; no writes or allocs are accepted while i_rst is low.
- Reads: combinational, zero latency. With ZERO_REG=1, address 0 always returns 0 and busy=0.
- Writes: committed on the rising edge.
  - Both ports enabled to the same address: port 1 wins, port 0 is dropped.
  - ZERO_REG=1: writes to address 0 are ignored (no array or busy change).
- Bypass (BYPASS=1): if port k address matches an enabled write address this cycle (and is not the hardwired zero), o_rs_data returns that write data. Port 1 has priority over port 0. With BYPASS=0, reads return the pre-edge array value.
- Scoreboard, per register r, evaluated at the clock edge:
  - set if i_alloc_en and i_alloc_addr==r
  - else clear if any enabled write targets r
  - else hold
  - Alloc and write to the same r in the same cycle: busy stays 1, because the new producer supersedes the one retiring.
  - Alloc to address 0 with ZERO_REG=1 is ignored.
  - Alloc to an already-busy register: stays busy, count unchanged.
  - Write to a non-busy register: data written, busy stays 0, count unchanged.
- o_rs_busy[k] = busy[addr_k], except forced 0 when BYPASS=1 and an enabled write to addr_k occurs this cycle and no alloc to addr_k occurs this cycle.
- o_pending: registered. next = current + (alloc sets a previously-clear bit) - (number of distinct previously-busy registers cleared this cycle). Range 0..DEPTH, never wraps. It must always equal the popcount of the busy bits; checked by assertion.
- All arithmetic is unsigned. Addresses are full AW bits with no out-of-range case.

Test Plan:
1. Reset mid-operation: write 0xDEADBEEF to r5, alloc r6, then drive i_rst=0 between edges -> o_rs_data(r5)=0 and busy(r6)=0 immediately, o_pending=0; after release, r5 reads 0.
2. Dual write collision: wr0(r3,0x11111111) + wr1(r3,0x22222222) same cycle -> next cycle r3 reads 0x22222222. Also wr0(r0,0xFFFFFFFF) -> r0 reads 0.
3. Bypass: BYPASS=1, rs port0=r7, wr1(r7,0xCAFEF00D) same cycle -> o_rs_data port0 = 0xCAFEF00D in that cycle. With BYPASS=0, the same stimulus returns the old r7 value that cycle and 0xCAFEF00D the next.
4. Scoreboard: alloc r9 -> busy(r9)=1, o_pending=1; wr0(r9) -> busy clears, o_pending=0. Alloc r9 + wr0(r9) same cycle -> busy stays 1, o_pending unchanged.
5. Dual retire: alloc r1, alloc r2, then wr0(r1)+wr1(r2) same cycle -> o_pending 2 -> 0. Alloc all 31 non-zero regs -> o_pending=31, no wrap; alloc r0 -> ignored.
6. Parameter sweep: DATA_W=64, DEPTH=16, NUM_RD=3, ZERO_REG=0 -> r0 is writable/allocatable, third read port returns correct 64-bit data, and o_pending reaches 16 when all registers are allocated.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (port 1 wins collisions),
// optional write-to-read bypass, and a per-register busy scoreboard with a registered pending count.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_RD*AW-1:0]     i_rs_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rs_data,
   output logic [NUM_RD-1:0]        o_rs_busy,
   input  logic                     i_wr0_en,
   input  logic [AW-1:0]            i_wr0_addr,
   input  logic [DATA_W-1:0]        i_wr0_data,
   input  logic                     i_wr1_en,
   input  logic [AW-1:0]            i_wr1_addr,
   input  logic [DATA_W-1:0]        i_wr1_data,
   input  logic                     i_alloc_en,
   input  logic [AW-1:0]            i_alloc_addr,
   output logic [CW-1:0]            o_pending
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CW-1:0]     pend_q, pend_d;
   logic              wr0_ok, wr1_ok, alloc_ok;
   logic              set_inc, clr0, clr1;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Qualified strobes; gating with reset keeps outputs at zero and blocks bypass while held.
   always_comb begin
      wr1_ok   = i_rst && i_wr1_en && !is_zero(i_wr1_addr);
      wr0_ok   = i_rst && i_wr0_en && !is_zero(i_wr0_addr)
                 && !(i_wr1_en && (i_wr1_addr == i_wr0_addr));
      alloc_ok = i_rst && i_alloc_en && !is_zero(i_alloc_addr);
   end

   always_comb begin
      busy_d = busy_q;
      if (wr0_ok)   busy_d[i_wr0_addr]   = 1'b0;
      if (wr1_ok)   busy_d[i_wr1_addr]   = 1'b0;
      if (alloc_ok) busy_d[i_alloc_addr] = 1'b1;
   end

   // wr0_ok already excludes wr1's address, so the two clears always hit distinct registers.
   always_comb begin
      set_inc = alloc_ok && !busy_q[i_alloc_addr];
      clr0    = wr0_ok && busy_q[i_wr0_addr] && !(alloc_ok && (i_alloc_addr == i_wr0_addr));
      clr1    = wr1_ok && busy_q[i_wr1_addr] && !(alloc_ok && (i_alloc_addr == i_wr1_addr));
      pend_d  = pend_q + {{(CW-1){1'b0}}, set_inc}
                       - {{(CW-1){1'b0}}, clr0}
                       - {{(CW-1){1'b0}}, clr1};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         if (wr0_ok) mem_q[i_wr0_addr] <= i_wr0_data;
         if (wr1_ok) mem_q[i_wr1_addr] <= i_wr1_data;
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) assert ($countones(busy_q) == int'(pend_q));
   end

   assign o_pending = pend_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit0, hit1, hit_alloc;
      assign ra        = i_rs_addr[k*AW +: AW];
      assign hit0      = (BYPASS != 0) && wr0_ok && (i_wr0_addr == ra);
      assign hit1      = (BYPASS != 0) && wr1_ok && (i_wr1_addr == ra);
      assign hit_alloc = alloc_ok && (i_alloc_addr == ra);
      assign o_rs_data[k*DATA_W +: DATA_W] = is_zero(ra) ? '0 :
                                             hit1        ? i_wr1_data :
                                             hit0        ? i_wr0_data : mem_q[ra];
      assign o_rs_busy[k] = busy_q[ra] && !((hit0 || hit1) && !hit_alloc);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default instance, a no-bypass twin on the same stimulus, and a 64-bit/16-deep/3-port variant.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic [9:0]  rs_addr;
   logic [63:0] rs_data, nb_rs_data;
   logic [1:0]  rs_busy, nb_rs_busy;
   logic        wr0_en, wr1_en, alloc_en;
   logic [4:0]  wr0_addr, wr1_addr, alloc_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [5:0]  pending, nb_pending;

   logic [11:0]  p_rs_addr;
   logic [191:0] p_rs_data;
   logic [2:0]   p_rs_busy;
   logic         p_wr0_en, p_wr1_en, p_alloc_en;
   logic [3:0]   p_wr0_addr, p_wr1_addr, p_alloc_addr;
   logic [63:0]  p_wr0_data, p_wr1_data;
   logic [4:0]   p_pending;

   always #5 clk = ~clk;

   regfile_mp u_dut (
      .i_clk(clk), .i_rst(rst_n), .i_rs_addr(rs_addr), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
      .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
      .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_pending(pending)
   );

   regfile_mp #(.BYPASS(0)) u_nb (
      .i_clk(clk), .i_rst(rst_n), .i_rs_addr(rs_addr), .o_rs_data(nb_rs_data), .o_rs_busy(nb_rs_busy),
      .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
      .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_pending(nb_pending)
   );

   regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0)) u_p (
      .i_clk(clk), .i_rst(rst_n), .i_rs_addr(p_rs_addr), .o_rs_data(p_rs_data), .o_rs_busy(p_rs_busy),
      .i_wr0_en(p_wr0_en), .i_wr0_addr(p_wr0_addr), .i_wr0_data(p_wr0_data),
      .i_wr1_en(p_wr1_en), .i_wr1_addr(p_wr1_addr), .i_wr1_data(p_wr1_data),
      .i_alloc_en(p_alloc_en), .i_alloc_addr(p_alloc_addr), .o_pending(p_pending)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      alloc_en = 1'b0; alloc_addr = '0;
   endtask

   task automatic p_idle();
      p_wr0_en = 1'b0; p_wr0_addr = '0; p_wr0_data = '0;
      p_wr1_en = 1'b0; p_wr1_addr = '0; p_wr1_data = '0;
      p_alloc_en = 1'b0; p_alloc_addr = '0;
   endtask

   initial begin
      idle();
      p_idle();
      rs_addr   = {5'd6, 5'd5};
      p_rs_addr = '0;
      #2;
      chk("reset_pending", 64'(pending), 64'd0);
      chk("reset_data", 64'(rs_data), 64'd0);
      chk("reset_busy", 64'(rs_busy), 64'd0);

      // Reset mid-operation
      step();
      rst_n = 1'b1;
      wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
      alloc_en = 1'b1; alloc_addr = 5'd6;
      step();
      idle();
      #1;
      chk("pre_rst_r5", 64'(rs_data[31:0]), 64'hDEADBEEF);
      chk("pre_rst_busy6", 64'(rs_busy[1]), 64'd1);
      chk("pre_rst_pending", 64'(pending), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_r5", 64'(rs_data[31:0]), 64'd0);
      chk("async_rst_busy6", 64'(rs_busy[1]), 64'd0);
      chk("async_rst_pending", 64'(pending), 64'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_r5", 64'(rs_data[31:0]), 64'd0);

      // Dual write collision, and writes to r0 ignored
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11111111;
      wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h22222222;
      step();
      idle();
      rs_addr = {5'd0, 5'd3};
      #1;
      chk("collision_r3", 64'(rs_data[31:0]), 64'h22222222);
      chk("collision_r3_nb", 64'(nb_rs_data[31:0]), 64'h22222222);
      wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
      #1;
      chk("r0_no_bypass", 64'(rs_data[63:32]), 64'd0);
      step();
      idle();
      #1;
      chk("r0_after_write", 64'(rs_data[63:32]), 64'd0);
      chk("r0_write_pending", 64'(pending), 64'd0);

      // Bypass vs. array-only read
      wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h12345678;
      step();
      idle();
      rs_addr = {5'd8, 5'd7};
      wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hCAFEF00D;
      #1;
      chk("bypass_r7", 64'(rs_data[31:0]), 64'hCAFEF00D);
      chk("nobypass_r7_old", 64'(nb_rs_data[31:0]), 64'h12345678);
      step();
      idle();
      #1;
      chk("nobypass_r7_new", 64'(nb_rs_data[31:0]), 64'hCAFEF00D);
      wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'hAAAA0000;
      wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'hBBBB1111;
      #1;
      chk("bypass_prio_wr1", 64'(rs_data[63:32]), 64'hBBBB1111);
      step();
      idle();

      // Busy forwarding on a retiring write
      alloc_en = 1'b1; alloc_addr = 5'd10;
      step();
      idle();
      rs_addr = {5'd0, 5'd10};
      #1;
      chk("busy_r10", 64'(rs_busy[0]), 64'd1);
      wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h00000001;
      #1;
      chk("busy_fwd_clear", 64'(rs_busy[0]), 64'd0);
      chk("busy_nb_held", 64'(nb_rs_busy[0]), 64'd1);
      chk("bypass_r10_data", 64'(rs_data[31:0]), 64'h1);
      alloc_en = 1'b1; alloc_addr = 5'd10;
      #1;
      chk("busy_alloc_and_wr", 64'(rs_busy[0]), 64'd1);
      step();
      idle();
      #1;
      chk("alloc_wr_r10_busy", 64'(rs_busy[0]), 64'd1);
      chk("alloc_wr_r10_pending", 64'(pending), 64'd1);
      wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h2;
      step();
      idle();
      #1;
      chk("r10_retired", 64'(pending), 64'd0);

      // Scoreboard on r9
      rs_addr = {5'd0, 5'd9};
      alloc_en = 1'b1; alloc_addr = 5'd9;
      step();
      idle();
      #1;
      chk("sb_alloc_busy", 64'(rs_busy[0]), 64'd1);
      chk("sb_alloc_pending", 64'(pending), 64'd1);
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
      step();
      idle();
      #1;
      chk("sb_wr_busy", 64'(rs_busy[0]), 64'd0);
      chk("sb_wr_pending", 64'(pending), 64'd0);
      alloc_en = 1'b1; alloc_addr = 5'd9;
      step();
      step();
      idle();
      #1;
      chk("sb_realloc_pending", 64'(pending), 64'd1);
      alloc_en = 1'b1; alloc_addr = 5'd9;
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h9A;
      step();
      idle();
      #1;
      chk("sb_same_cycle_busy", 64'(rs_busy[0]), 64'd1);
      chk("sb_same_cycle_pending", 64'(pending), 64'd1);
      chk("sb_same_cycle_data", 64'(rs_data[31:0]), 64'h9A);
      wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h0;
      step();
      idle();
      #1;
      chk("sb_wr1_clear", 64'(pending), 64'd0);

      // Dual retire and saturation to the full set
      alloc_en = 1'b1; alloc_addr = 5'd1;
      step();
      alloc_addr = 5'd2;
      step();
      idle();
      #1;
      chk("dual_pending2", 64'(pending), 64'd2);
      wr0_en = 1'b1; wr0_addr = 5'd1;
      wr1_en = 1'b1; wr1_addr = 5'd2;
      step();
      idle();
      #1;
      chk("dual_retire", 64'(pending), 64'd0);
      for (int r = 1; r < 32; r++) begin
         alloc_en = 1'b1; alloc_addr = 5'(r);
         step();
      end
      idle();
      #1;
      chk("all_alloc_pending", 64'(pending), 64'd31);
      alloc_en = 1'b1; alloc_addr = 5'd0;
      step();
      idle();
      rs_addr = {5'd31, 5'd0};
      #1;
      chk("r0_alloc_pending", 64'(pending), 64'd31);
      chk("r0_alloc_busy", 64'(rs_busy), 64'b10);

      // Wide, shallow, three-port variant without a hardwired zero
      p_wr0_en = 1'b1; p_wr0_addr = 4'd0;  p_wr0_data = 64'h0123456789ABCDEF;
      p_wr1_en = 1'b1; p_wr1_addr = 4'd15; p_wr1_data = 64'hFEDCBA9876543210;
      step();
      p_idle();
      p_rs_addr = {4'd15, 4'd3, 4'd0};
      #1;
      chk("p_r0_data", p_rs_data[63:0], 64'h0123456789ABCDEF);
      chk("p_port1_r3", p_rs_data[127:64], 64'd0);
      chk("p_port2_r15", p_rs_data[191:128], 64'hFEDCBA9876543210);
      for (int r = 0; r < 16; r++) begin
         p_alloc_en = 1'b1; p_alloc_addr = 4'(r);
         step();
      end
      p_idle();
      #1;
      chk("p_all_pending", 64'(p_pending), 64'd16);
      chk("p_all_busy", 64'(p_rs_busy), 64'b111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
